// File: rtl/xotr_phase_sequencer.sv
// xotr_phase_sequencer
// Sequences the opcode execute phase that drives the XOTR decoder tree.
// Holds the opcode latch (Source/notSource), the execute phase timer
// (XPT/notXPT), the CM1/XOTR phase flags, IFF1/IFF2 and the interrupt
// acknowledge taken at instruction boundaries.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   Ready               bus ready; when low every register holds
//   OpcodeIn/Valid      fetched opcode byte and its qualifier (FETCH only)
//   PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd
//                       decoder end-of-instruction strobes (must agree)
//   P2_RestoreIFF       decoder: IFF1 <= IFF2
//   EI_Req, DI_Req      enable / disable interrupts
//   IntReq              maskable interrupt request level
//   XPT/notXPT          phase timer and its registered complement
//   Source/notSource    latched opcode and its registered complement
//   XOTR_Enable, CM1, Fetch_Req, IntAck
//                       phase flags toward decoder and bus
//   IFF1, IFF2          interrupt enable flip-flops
//   OphdCount           handled-opcode count (wraps)
//   Fault               sticky protocol error
module xotr_phase_sequencer #(
  parameter int XPT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Ready,
  input  logic [7:0]       OpcodeIn,
  input  logic             OpcodeValid,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Set_CM1,
  input  logic             P2_Reset_XOTR,
  input  logic             Pa_Ophd,
  input  logic             P2_RestoreIFF,
  input  logic             EI_Req,
  input  logic             DI_Req,
  input  logic             IntReq,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [7:0]       Source,
  output logic [7:0]       notSource,
  output logic             XOTR_Enable,
  output logic             CM1,
  output logic             Fetch_Req,
  output logic             IntAck,
  output logic             IFF1,
  output logic             IFF2,
  output logic [CNT_W-1:0] OphdCount,
  output logic             Fault
);

  typedef enum logic [1:0] {FETCH, EXEC, FAULT} state_t;

  localparam logic [XPT_W-1:0] XPT_MAX = '1;

  state_t     state;
  logic       ei_pending;
  logic [3:0] strobes;
  logic       strobe_all;
  logic       strobe_none;
  logic       instr_end;
  logic       exec_fault;
  logic       iff1_next;
  logic       iff2_next;
  logic       pend_next;
  logic       take_int;

  assign strobes     = {P2_Set_CM1, P2_Reset_XOTR, PR_Reset_XPT, Pa_Ophd};
  assign strobe_all  = &strobes;
  assign strobe_none = ~|strobes;
  assign instr_end   = Ready && (state == EXEC) && strobe_all;
  // Split strobes are a protocol error; so is running past the last phase.
  assign exec_fault  = !strobe_all && (!strobe_none || (XPT == XPT_MAX));

  // Interrupt-enable bookkeeping. DI wins outright; otherwise a restore is
  // applied first so that the restored IFF1 is the one sampled at the end.
  always_comb begin
    iff1_next = IFF1;
    iff2_next = IFF2;
    pend_next = ei_pending;
    take_int  = 1'b0;
    if (Ready && (state != FAULT)) begin
      if (DI_Req) begin
        iff1_next = 1'b0;
        iff2_next = 1'b0;
        pend_next = 1'b0;
      end else begin
        if (EI_Req) pend_next = 1'b1;
        if ((state == EXEC) && P2_RestoreIFF) iff1_next = IFF2;
        if (instr_end) begin
          if (pend_next) begin
            // EI takes effect here; interrupts are not sampled on this end.
            iff1_next = 1'b1;
            iff2_next = 1'b1;
            pend_next = 1'b0;
          end else if (IntReq && iff1_next) begin
            iff1_next = 1'b0;
            iff2_next = 1'b0;
            take_int  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      XPT         <= '0;
      notXPT      <= '1;
      Source      <= 8'h00;
      notSource   <= 8'hFF;
      CM1         <= 1'b1;
      XOTR_Enable <= 1'b0;
      Fetch_Req   <= 1'b1;
      IntAck      <= 1'b0;
      IFF1        <= 1'b0;
      IFF2        <= 1'b0;
      ei_pending  <= 1'b0;
      OphdCount   <= '0;
      Fault       <= 1'b0;
    end else begin
      IFF1       <= iff1_next;
      IFF2       <= iff2_next;
      ei_pending <= pend_next;
      if (Ready) begin
        case (state)
          FETCH: begin
            if (OpcodeValid) begin
              Source      <= OpcodeIn;
              notSource   <= ~OpcodeIn;
              XPT         <= '0;
              notXPT      <= '1;
              state       <= EXEC;
              CM1         <= 1'b0;
              XOTR_Enable <= 1'b1;
              Fetch_Req   <= 1'b0;
              IntAck      <= 1'b0;
            end
          end
          EXEC: begin
            if (strobe_all) begin
              OphdCount   <= OphdCount + 1'b1;
              XPT         <= '0;
              notXPT      <= '1;
              state       <= FETCH;
              CM1         <= 1'b1;
              Fetch_Req   <= 1'b1;
              XOTR_Enable <= 1'b0;
              IntAck      <= take_int;
            end else if (exec_fault) begin
              // XPT and Source stay frozen from here until reset.
              state       <= FAULT;
              Fault       <= 1'b1;
              XOTR_Enable <= 1'b0;
              Fetch_Req   <= 1'b0;
              CM1         <= 1'b0;
              IntAck      <= 1'b0;
            end else begin
              XPT    <= XPT + 1'b1;
              notXPT <= ~(XPT + 1'b1);
            end
          end
          default: begin
            state <= FAULT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xotr_phase_sequencer.sv
// Testbench for xotr_phase_sequencer: directed scenarios with literal
// expectations, followed by randomized traffic, all compared every cycle
// against a mode-level behavioural model. The counter width is reduced so
// that OphdCount wrap-around occurs within the random phase.
module tb_xotr_phase_sequencer;

  localparam int XPT_W   = 5;
  localparam int CNT_W   = 4;
  localparam int XPT_TOP = (1 << XPT_W) - 1;
  localparam int CNT_MOD = 1 << CNT_W;

  localparam int M_FETCH = 0;
  localparam int M_EXEC  = 1;
  localparam int M_FAULT = 2;

  logic clock = 1'b0;
  logic reset, Ready, OpcodeValid;
  logic [7:0] OpcodeIn;
  logic PR_Reset_XPT, P2_Set_CM1, P2_Reset_XOTR, Pa_Ophd;
  logic P2_RestoreIFF, EI_Req, DI_Req, IntReq;
  logic [XPT_W-1:0] XPT, notXPT;
  logic [7:0] Source, notSource;
  logic XOTR_Enable, CM1, Fetch_Req, IntAck, IFF1, IFF2, Fault;
  logic [CNT_W-1:0] OphdCount;

  xotr_phase_sequencer #(.XPT_W(XPT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .Ready(Ready),
    .OpcodeIn(OpcodeIn), .OpcodeValid(OpcodeValid),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1),
    .P2_Reset_XOTR(P2_Reset_XOTR), .Pa_Ophd(Pa_Ophd),
    .P2_RestoreIFF(P2_RestoreIFF), .EI_Req(EI_Req), .DI_Req(DI_Req),
    .IntReq(IntReq), .XPT(XPT), .notXPT(notXPT), .Source(Source),
    .notSource(notSource), .XOTR_Enable(XOTR_Enable), .CM1(CM1),
    .Fetch_Req(Fetch_Req), .IntAck(IntAck), .IFF1(IFF1), .IFF2(IFF2),
    .OphdCount(OphdCount), .Fault(Fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: instruction-level mode plus plain integers.
  int m_mode, m_xpt, m_src, m_cnt;
  bit m_iff1, m_iff2, m_pend, m_ack;
  int nstb;
  bit took;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = M_FETCH; m_xpt = 0; m_src = 0; m_cnt = 0;
      m_iff1 = 0; m_iff2 = 0; m_pend = 0; m_ack = 0;
    end else if (Ready && m_mode != M_FAULT) begin
      nstb = int'(P2_Set_CM1) + int'(P2_Reset_XOTR) + int'(PR_Reset_XPT) + int'(Pa_Ophd);
      took = 0;
      if (DI_Req) begin
        m_iff1 = 0; m_iff2 = 0; m_pend = 0;
      end else begin
        if (EI_Req) m_pend = 1;
        if (m_mode == M_EXEC && P2_RestoreIFF) m_iff1 = m_iff2;
        if (m_mode == M_EXEC && nstb == 4) begin
          if (m_pend) begin
            m_iff1 = 1; m_iff2 = 1; m_pend = 0;
          end else if (IntReq && m_iff1) begin
            m_iff1 = 0; m_iff2 = 0; took = 1;
          end
        end
      end
      if (m_mode == M_FETCH) begin
        if (OpcodeValid) begin
          m_src = int'(OpcodeIn); m_xpt = 0; m_mode = M_EXEC; m_ack = 0;
        end
      end else begin
        if (nstb == 4) begin
          m_cnt = (m_cnt + 1) % CNT_MOD; m_xpt = 0; m_mode = M_FETCH; m_ack = took;
        end else if (nstb != 0 || m_xpt == XPT_TOP) begin
          m_mode = M_FAULT; m_ack = 0;
        end else begin
          m_xpt = m_xpt + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("XPT", 32'(XPT), 32'(m_xpt));
      chk("notXPT", 32'(notXPT), 32'(XPT_TOP - m_xpt));
      chk("Source", 32'(Source), 32'(m_src));
      chk("notSource", 32'(notSource), 32'(255 - m_src));
      chk("XOTR_Enable", 32'(XOTR_Enable), 32'(m_mode == M_EXEC));
      chk("CM1", 32'(CM1), 32'(m_mode == M_FETCH));
      chk("Fetch_Req", 32'(Fetch_Req), 32'(m_mode == M_FETCH));
      chk("Fault", 32'(Fault), 32'(m_mode == M_FAULT));
      chk("IntAck", 32'(IntAck), 32'(m_ack && m_mode == M_FETCH));
      chk("IFF1", 32'(IFF1), 32'(m_iff1));
      chk("IFF2", 32'(IFF2), 32'(m_iff2));
      chk("OphdCount", 32'(OphdCount), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic quiet();
    reset = 0; Ready = 1; OpcodeValid = 0; OpcodeIn = 8'h00;
    PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Reset_XOTR = 0; Pa_Ophd = 0;
    P2_RestoreIFF = 0; EI_Req = 0; DI_Req = 0;
  endtask

  task automatic ends(input logic v);
    PR_Reset_XPT = v; P2_Set_CM1 = v; P2_Reset_XOTR = v; Pa_Ophd = v;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; tick(); reset = 0;
  endtask

  task automatic fetch(input logic [7:0] op);
    quiet(); OpcodeValid = 1; OpcodeIn = op; tick(); OpcodeValid = 0;
  endtask

  task automatic end_instr();
    quiet(); ends(1); tick(); ends(0);
  endtask

  int r;

  initial begin
    quiet(); IntReq = 0;
    reset = 1; tick(); checking = 1; tick(); reset = 0;

    chk("rst_XPT", 32'(XPT), 0);
    chk("rst_notXPT", 32'(notXPT), 32'h1F);
    chk("rst_notSource", 32'(notSource), 32'hFF);
    chk("rst_CM1", 32'(CM1), 1);
    chk("rst_Fetch_Req", 32'(Fetch_Req), 1);
    chk("rst_XOTR_Enable", 32'(XOTR_Enable), 0);

    fetch(8'h44);
    chk("op_Source", 32'(Source), 32'h44);
    chk("op_notSource", 32'(notSource), 32'hBB);
    chk("op_Enable", 32'(XOTR_Enable), 1);
    repeat (3) tick();
    chk("quiet_XPT", 32'(XPT), 3);
    chk("quiet_notXPT", 32'(notXPT), 32'h1C);
    end_instr();
    chk("end_CM1", 32'(CM1), 1);
    chk("end_Fetch_Req", 32'(Fetch_Req), 1);
    chk("end_XPT", 32'(XPT), 0);
    chk("end_Count", 32'(OphdCount), 1);

    // Ready low: strobes must be ignored and XPT must hold.
    fetch(8'h10);
    repeat (2) tick();
    Ready = 0; ends(1);
    repeat (4) tick();
    chk("stall_XPT", 32'(XPT), 2);
    chk("stall_Enable", 32'(XOTR_Enable), 1);
    quiet(); tick();
    chk("resume_XPT", 32'(XPT), 3);

    // A lone end strobe is a protocol error.
    P2_Reset_XOTR = 1; tick(); quiet();
    chk("split_Fault", 32'(Fault), 1);
    chk("split_Enable", 32'(XOTR_Enable), 0);
    repeat (2) tick();
    chk("fault_XPT_frozen", 32'(XPT), 3);
    do_reset();
    chk("clr_Fault", 32'(Fault), 0);
    chk("clr_CM1", 32'(CM1), 1);

    // Phase timer runs out.
    fetch(8'h7E);
    repeat (31) tick();
    chk("max_XPT", 32'(XPT), 31);
    chk("max_noFault", 32'(Fault), 0);
    tick();
    chk("ovf_Fault", 32'(Fault), 1);
    chk("ovf_XPT", 32'(XPT), 31);
    do_reset();

    // EI delays one instruction, then the held request is taken.
    IntReq = 1;
    fetch(8'hFB);
    EI_Req = 1; tick(); EI_Req = 0;
    end_instr();
    chk("ei_IFF1", 32'(IFF1), 1);
    chk("ei_IFF2", 32'(IFF2), 1);
    chk("ei_IntAck", 32'(IntAck), 0);
    fetch(8'h00);
    tick();
    end_instr();
    chk("int_IntAck", 32'(IntAck), 1);
    chk("int_IFF1", 32'(IFF1), 0);
    chk("int_IFF2", 32'(IFF2), 0);

    // Restore coinciding with the end, then the same with DI.
    fetch(8'h01); EI_Req = 1; tick(); end_instr();
    fetch(8'hED); ends(1); P2_RestoreIFF = 1; tick(); quiet();
    chk("restore_IntAck", 32'(IntAck), 1);
    fetch(8'h02); EI_Req = 1; tick(); end_instr();
    fetch(8'hED); ends(1); P2_RestoreIFF = 1; DI_Req = 1; tick(); quiet();
    chk("di_IntAck", 32'(IntAck), 0);
    chk("di_IFF1", 32'(IFF1), 0);
    chk("di_IFF2", 32'(IFF2), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      quiet();
      Ready = ($urandom_range(99, 0) < 85);
      OpcodeValid = ($urandom_range(99, 0) < 60);
      OpcodeIn = 8'($urandom);
      r = $urandom_range(99, 0);
      if (r < 15) ends(1);
      else if (r < 16) begin
        {P2_Set_CM1, P2_Reset_XOTR, PR_Reset_XPT, Pa_Ophd} = 4'($urandom);
      end
      EI_Req = ($urandom_range(99, 0) < 5);
      DI_Req = ($urandom_range(99, 0) < 3);
      P2_RestoreIFF = ($urandom_range(99, 0) < 5);
      IntReq = ($urandom_range(99, 0) < 50);
      if ((m_mode == M_FAULT && $urandom_range(3, 0) == 0) || $urandom_range(999, 0) < 3)
        reset = 1;
      tick();
    end

    quiet(); tick();
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
